// File: rtl/apb_requester.sv
// ---------------------------------------------------------------------------
// apb_requester
//   APB requester. Takes one read/write command at a time on a valid/ready
//   command port, runs the APB SETUP/ACCESS sequence against a completer, and
//   returns read data plus error/timeout status on a valid/ready response port.
//
// Ports
//   PCLK, PRESET            clock (rising edge), async active-low reset
//   cmd_valid/cmd_ready     command handshake (cmd_ready is combinational)
//   cmd_write/addr/wdata    command payload, sampled only at acceptance
//   rsp_valid/rsp_ready     response handshake
//   rsp_rdata/err/timeout   response payload, stable while rsp_valid is high
//   PSEL..PWDATA            APB request outputs (registered)
//   PRDATA/PREADY/PSLVERR   APB completer inputs, only looked at in ACCESS
// ---------------------------------------------------------------------------
module apb_requester #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  // Last counter value before abort; only meaningful when the timeout is enabled.
  localparam bit               TO_EN   = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] TO_LAST = TO_EN ? CNT_W'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t r_state, w_state_nxt;

  logic              r_psel, w_psel_nxt;
  logic              r_penable, w_penable_nxt;
  logic              r_pwrite, w_pwrite_nxt;
  logic [ADDR_W-1:0] r_paddr, w_paddr_nxt;
  logic [DATA_W-1:0] r_pwdata, w_pwdata_nxt;
  logic              r_rsp_valid, w_rsp_valid_nxt;
  logic [DATA_W-1:0] r_rsp_rdata, w_rsp_rdata_nxt;
  logic              r_rsp_err, w_rsp_err_nxt;
  logic              r_rsp_timeout, w_rsp_timeout_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;

  logic w_accept;
  logic w_expired;

  // Reset is folded in so nothing is accepted while PRESET is low.
  assign cmd_ready = (r_state == S_IDLE) & PRESET;
  assign w_accept  = cmd_valid & cmd_ready;
  assign w_expired = TO_EN & (r_cnt == TO_LAST);

  // State register
  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:   if (w_accept) w_state_nxt = S_SETUP;
      S_SETUP:  w_state_nxt = S_ACCESS;
      S_ACCESS: if (PREADY || w_expired) w_state_nxt = S_RESP;
      S_RESP:   if (rsp_ready) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Next values of the registered outputs and the wait counter
  always_comb begin
    w_psel_nxt        = r_psel;
    w_penable_nxt     = r_penable;
    w_pwrite_nxt      = r_pwrite;
    w_paddr_nxt       = r_paddr;
    w_pwdata_nxt      = r_pwdata;
    w_rsp_valid_nxt   = r_rsp_valid;
    w_rsp_rdata_nxt   = r_rsp_rdata;
    w_rsp_err_nxt     = r_rsp_err;
    w_rsp_timeout_nxt = r_rsp_timeout;
    w_cnt_nxt         = r_cnt;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_psel_nxt    = 1'b1;
          w_penable_nxt = 1'b0;
          w_pwrite_nxt  = cmd_write;
          w_paddr_nxt   = cmd_addr;
          w_pwdata_nxt  = cmd_wdata;
        end
      end
      S_SETUP: begin
        w_penable_nxt = 1'b1;
        w_cnt_nxt     = '0;
      end
      S_ACCESS: begin
        if (PREADY) begin
          w_psel_nxt        = 1'b0;
          w_penable_nxt     = 1'b0;
          w_rsp_valid_nxt   = 1'b1;
          w_rsp_err_nxt     = PSLVERR;
          w_rsp_timeout_nxt = 1'b0;
          w_rsp_rdata_nxt   = (!r_pwrite && !PSLVERR) ? PRDATA : '0;
        end else if (w_expired) begin
          w_psel_nxt        = 1'b0;
          w_penable_nxt     = 1'b0;
          w_rsp_valid_nxt   = 1'b1;
          w_rsp_err_nxt     = 1'b1;
          w_rsp_timeout_nxt = 1'b1;
          w_rsp_rdata_nxt   = '0;
        end else if (r_cnt != CNT_MAX) begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_RESP: begin
        if (rsp_ready) w_rsp_valid_nxt = 1'b0;
      end
      default: ;
    endcase
  end

  // Output / counter registers
  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      r_psel        <= 1'b0;
      r_penable     <= 1'b0;
      r_pwrite      <= 1'b0;
      r_paddr       <= '0;
      r_pwdata      <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_err     <= 1'b0;
      r_rsp_timeout <= 1'b0;
      r_cnt         <= '0;
    end else begin
      r_psel        <= w_psel_nxt;
      r_penable     <= w_penable_nxt;
      r_pwrite      <= w_pwrite_nxt;
      r_paddr       <= w_paddr_nxt;
      r_pwdata      <= w_pwdata_nxt;
      r_rsp_valid   <= w_rsp_valid_nxt;
      r_rsp_rdata   <= w_rsp_rdata_nxt;
      r_rsp_err     <= w_rsp_err_nxt;
      r_rsp_timeout <= w_rsp_timeout_nxt;
      r_cnt         <= w_cnt_nxt;
    end
  end

  assign PSEL        = r_psel;
  assign PENABLE     = r_penable;
  assign PWRITE      = r_pwrite;
  assign PADDR       = r_paddr;
  assign PWDATA      = r_pwdata;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_rdata   = r_rsp_rdata;
  assign rsp_err     = r_rsp_err;
  assign rsp_timeout = r_rsp_timeout;

endmodule
